// File: rtl/arcade_input_cond_pkg.sv
// Shared bit map and coin FSM state type for the cabinet input conditioner.
package arcade_input_pkg;
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_BOMB   = 5;
  localparam int JOY_START1 = 6;
  localparam int JOY_START2 = 7;
  localparam int JOY_COIN   = 8;
  localparam int NUM_IN     = 9;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_ON   = 2'd1,
    C_GAP  = 2'd2
  } coin_state_t;
endpackage

// File: rtl/arcade_input_debounce.sv
// Per-bit tick-based debouncer: a raw bit must disagree for DEB_TICKS ticks to be accepted.
module input_debounce #(
  parameter int WIDTH     = 9,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);
  localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic [WIDTH-1:0]         deb_q, deb_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (tick_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (raw_i[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = raw_i[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;
endmodule

// File: rtl/arcade_input_cond.sv
// Cabinet input conditioner: debounce, opposing-direction cleanup and coin pulse shaping.
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int TICK_DIV       = 18432,
  parameter int DEB_TICKS      = 4,
  parameter int COIN_ON_TICKS  = 100,
  parameter int COIN_OFF_TICKS = 100,
  parameter int COIN_QUEUE     = 3
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        pause_i,
  input  logic [15:0] joy_in_i,
  output logic        up_o,
  output logic        down_o,
  output logic        left_o,
  output logic        right_o,
  output logic        fire_o,
  output logic        bomb_o,
  output logic        start1_o,
  output logic        start2_o,
  output logic        coin_o,
  output logic        coin_busy_o,
  output logic [2:0]  coin_pending_o
);
  localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (COIN_ON_TICKS > COIN_OFF_TICKS) ? COIN_ON_TICKS : COIN_OFF_TICKS;
  localparam int CCW  = $clog2(CMAX + 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [CCW-1:0] ON_LOAD   = CCW'(COIN_ON_TICKS);
  localparam logic [CCW-1:0] OFF_LOAD  = CCW'(COIN_OFF_TICKS);
  localparam logic [2:0]     QMAX      = 3'(COIN_QUEUE);

  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NUM_IN-1:0] deb;
  logic [7:0]        btn_q, btn_d;
  logic              coin_prev_q, coin_edge, deq;
  logic [2:0]        pend_q, pend_d;
  coin_state_t       state_q;
  logic [CCW-1:0]    ccnt_q;
  logic              coin_q, busy_q;
  logic              unused_joy;

  assign unused_joy = ^joy_in_i[15:NUM_IN];

  // Pause freezes the divider, so every downstream timer stalls with it.
  assign tick = ~pause_i & (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!pause_i) tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
  end

  input_debounce #(
    .WIDTH     (NUM_IN),
    .DEB_TICKS (DEB_TICKS)
  ) u_deb (
    .clk_i  (clk_sys_i),
    .rst_i  (reset_i),
    .tick_i (tick),
    .raw_i  (joy_in_i[NUM_IN-1:0]),
    .deb_o  (deb)
  );

  always_comb begin
    btn_d = '0;
    if (!pause_i)
      btn_d = {deb[JOY_UP]    & ~deb[JOY_DOWN],  deb[JOY_DOWN]  & ~deb[JOY_UP],
               deb[JOY_LEFT]  & ~deb[JOY_RIGHT], deb[JOY_RIGHT] & ~deb[JOY_LEFT],
               deb[JOY_FIRE], deb[JOY_BOMB], deb[JOY_START1], deb[JOY_START2]};
  end

  assign coin_edge = deb[JOY_COIN] & ~coin_prev_q;
  assign deq       = tick & (state_q == C_IDLE) & (pend_q != 3'd0);

  // An enqueue and dequeue in the same cycle cancel out, even at saturation.
  always_comb begin
    pend_d = pend_q;
    if (coin_edge && !deq && pend_q != QMAX) pend_d = pend_q + 3'd1;
    else if (deq && !coin_edge)              pend_d = pend_q - 3'd1;
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      tick_cnt_q  <= '0;
      btn_q       <= '0;
      coin_prev_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      btn_q       <= btn_d;
      coin_prev_q <= deb[JOY_COIN];
      pend_q      <= pend_d;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q <= C_IDLE;
      ccnt_q  <= '0;
      coin_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        C_IDLE: if (pend_q != 3'd0) begin
          state_q <= C_ON;
          ccnt_q  <= ON_LOAD;
          coin_q  <= 1'b1;
          busy_q  <= 1'b1;
        end
        C_ON: if (ccnt_q == CCW'(1)) begin
          state_q <= C_GAP;
          ccnt_q  <= OFF_LOAD;
          coin_q  <= 1'b0;
        end else begin
          ccnt_q <= ccnt_q - 1'b1;
        end
        C_GAP: if (ccnt_q == CCW'(1)) begin
          state_q <= C_IDLE;
          ccnt_q  <= '0;
          busy_q  <= 1'b0;
        end else begin
          ccnt_q <= ccnt_q - 1'b1;
        end
        default: begin
          state_q <= C_IDLE;
          ccnt_q  <= '0;
          coin_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {up_o, down_o, left_o, right_o, fire_o, bomb_o, start1_o, start2_o} = btn_q;
  assign coin_o         = coin_q;
  assign coin_busy_o    = busy_q;
  assign coin_pending_o = pend_q;
endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed + random bench for arcade_input_cond against a tick/phase-level behavioural model.
module tb_arcade_input_cond;
  localparam int TD = 4, DB = 2, CON = 3, COFF = 2, CQ = 3;

  logic        clk = 1'b0, rst = 1'b1, pause = 1'b0;
  logic [15:0] joy = '0;
  logic        up, down, left, right, fire, bomb, st1, st2, coin, busy;
  logic [2:0]  pend;

  arcade_input_cond #(
    .TICK_DIV(TD), .DEB_TICKS(DB), .COIN_ON_TICKS(CON), .COIN_OFF_TICKS(COFF), .COIN_QUEUE(CQ)
  ) dut (
    .clk_sys_i(clk), .reset_i(rst), .pause_i(pause), .joy_in_i(joy),
    .up_o(up), .down_o(down), .left_o(left), .right_o(right),
    .fire_o(fire), .bomb_o(bomb), .start1_o(st1), .start2_o(st2),
    .coin_o(coin), .coin_busy_o(busy), .coin_pending_o(pend)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;

  // Model: active-cycle count gives tick timing; debounce as mismatch run length;
  // coin as phase + remaining ticks, queue as a plain integer.
  int act, m_phase, m_left, m_pend, m_acc = 0;
  int m_run [9];
  logic [8:0]  m_deb;
  logic        m_seen;
  logic [12:0] m_out;

  int   hi = 0, lo = 0, bz = 0, pulses = 0, peak = 0;
  logic last_coin = 1'b0, last_busy = 1'b0, have_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    logic tk, edge_c, dq;
    logic [8:0] d;
    if (rst) begin
      act = 0; m_deb = '0; m_seen = 1'b0; m_phase = 0; m_left = 0; m_pend = 0; m_out = '0;
      foreach (m_run[i]) m_run[i] = 0;
      return;
    end
    d  = m_deb;
    tk = !pause && (act % TD == TD - 1);
    if (!pause) act++;
    edge_c = d[8] && !m_seen;
    m_seen = d[8];
    dq = tk && m_phase == 0 && m_pend > 0;
    if (edge_c && dq) m_acc++;
    else if (edge_c && m_pend < CQ) begin m_pend++; m_acc++; end
    else if (dq) m_pend--;
    if (tk) begin
      if (m_phase == 0) begin
        if (dq) begin m_phase = 1; m_left = CON; end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == 1) begin m_phase = 2; m_left = COFF; end
          else m_phase = 0;
        end
      end
      for (int i = 0; i < 9; i++) begin
        if (joy[i] == m_deb[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= DB) begin m_deb[i] = joy[i]; m_run[i] = 0; end
        else m_run[i]++;
      end
    end
    m_out[12:5] = pause ? 8'h00 : {d[3] & ~d[2], d[2] & ~d[3], d[1] & ~d[0], d[0] & ~d[1],
                                   d[4], d[5], d[6], d[7]};
    m_out[4]   = (m_phase == 1);
    m_out[3]   = (m_phase != 0);
    m_out[2:0] = 3'(m_pend);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    if (!rst && !pause) begin
      if (last_coin) hi++; else lo++;
      if (last_busy) bz++;
    end
    #1;
    chk("cycle", {19'd0, up, down, left, right, fire, bomb, st1, st2, coin, busy, pend}, {19'd0, m_out});
    if (rst) begin
      hi = 0; lo = 0; bz = 0; have_prev = 1'b0;
    end else begin
      if (coin && !last_coin) begin
        if (have_prev) chk("coin_gap_ge8", 32'(lo >= COFF * TD), 1);
        pulses++; hi = 0;
      end
      if (!coin && last_coin) begin chk("coin_hi_len", hi, CON * TD); lo = 0; have_prev = 1'b1; end
      if (busy && !last_busy) bz = 0;
      if (!busy && last_busy) chk("busy_len", bz, (CON + COFF) * TD);
      if (int'(pend) > peak) peak = int'(pend);
    end
    last_coin = coin; last_busy = busy;
  endtask

  initial begin
    int p0, a0, tc, mx;
    logic ok, saw1;

    repeat (3) cyc();
    chk("reset_outs", {19'd0, up, down, left, right, fire, bomb, st1, st2, coin, busy, pend}, 0);
    chk("reset_tick_cnt", 32'(dut.tick_cnt_q), 0);
    rst = 1'b0;

    repeat (10) cyc();
    joy[4] = 1'b1;
    repeat (16) cyc();
    chk("fire_on", fire, 1);
    joy[4] = 1'b0;
    repeat (16) cyc();
    chk("fire_off", fire, 0);
    joy[4] = 1'b1;
    repeat (TD) cyc();
    joy[4] = 1'b0;
    mx = 0;
    repeat (16) begin cyc(); mx |= int'(fire); end
    chk("fire_glitch", mx, 0);

    joy[3:0] = 4'b1111;
    repeat (16) cyc();
    chk("socd_both", {28'd0, up, down, left, right}, 0);
    joy[2] = 1'b0; joy[1] = 1'b0;
    repeat (16) cyc();
    chk("socd_up_right", {28'd0, up, down, left, right}, 32'b1001);
    joy[3:0] = 4'b0000;
    repeat (16) cyc();

    p0 = pulses; saw1 = 1'b0;
    joy[8] = 1'b1;
    repeat (12) begin cyc(); saw1 |= (pend == 3'd1); end
    joy[8] = 1'b0;
    repeat (44) begin cyc(); saw1 |= (pend == 3'd1); end
    chk("single_saw_pend1", saw1, 1);
    chk("single_pulses", pulses - p0, 1);
    chk("single_pend_empty", pend, 0);

    p0 = pulses; a0 = m_acc; peak = 0;
    for (int k = 0; k < 14; k++) begin
      joy[8] = 1'b1; repeat (8) cyc();
      joy[8] = 1'b0; repeat (8) cyc();
    end
    repeat (160) cyc();
    chk("queue_peak", peak, CQ);
    chk("queue_pulses", pulses - p0, m_acc - a0);
    chk("queue_drained", {29'd0, pend}, 0);

    joy = 16'h0018;
    repeat (12) cyc();
    joy[8] = 1'b1; repeat (8) cyc(); joy[8] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); ok = coin; end
    chk("pause_wait_coin", ok, 1);
    repeat (4) cyc();
    tc = act % TD;
    pause = 1'b1;
    repeat (40) cyc();
    chk("pause_coin_held", coin, 1);
    chk("pause_up_fire_0", {30'd0, up, fire}, 0);
    chk("pause_tick_cnt", 32'(dut.tick_cnt_q), tc);
    pause = 1'b0;
    cyc();
    chk("resume_up_fire", {30'd0, up, fire}, 3);
    repeat (40) cyc();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) joy[$urandom_range(0, 8)] ^= 1'b1;
      joy[15:9] = 7'($urandom);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      cyc();
    end
    pause = 1'b0;
    joy = 16'h0018;
    repeat (16) cyc();

    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      joy[8] = ((i / 8) % 2 == 0);
      cyc();
      ok = coin && pend == 3'd2;
    end
    chk("reach_pend2", ok, 1);
    rst = 1'b1;
    cyc();
    chk("rst_mid_all0", {19'd0, up, down, left, right, fire, bomb, st1, st2, coin, busy, pend}, 0);
    rst = 1'b0;
    repeat (20) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Input conditioner sitting between hps_io joystick outputs (joystick_0 | joystick_1) and the xevious core's cabinet inputs.
- Debounces the buttons and suppresses opposing joystick directions.
- Turns coin presses into arcade-length coin pulses with a mandatory gap between them, queuing presses that arrive during a pulse.
- Freezes cleanly while the pause block holds the CPU, so no input events are lost or duplicated across a pause.

Parameters:
- TICK_DIV, 18432, clk_sys cycles per timing tick (about 1 ms at 18.432 MHz).
- DEB_TICKS, 4, consecutive ticks a raw input must differ from its debounced value before the debounced value changes (>=1).
- COIN_ON_TICKS, 100, coin pulse high time in ticks (>=1).
- COIN_OFF_TICKS, 100, minimum coin low gap after a pulse, in ticks (>=1).
- COIN_QUEUE, 3, maximum pending coin presses (1..7).

Ports:
- clk_sys in 1: system clock.
- reset in 1: synchronous, active-high reset.
- pause in 1: pause_cpu from the pause block; freezes the block.
- joy_in in 16: raw joystick word.
  - Bit map: [0] right, [1] left, [2] down, [3] up, [4] fire, [5] bomb, [6] start1, [7] start2, [8] coin.
  - Other bits are ignored.
- up, down, left, right out 1 each: conditioned directions, active high.
- fire, bomb, start1, start2 out 1 each: conditioned buttons, active high.
- coin out 1: shaped coin pulse.
- coin_busy out 1: high while the coin FSM is in C_ON or C_GAP.
- coin_pending out 3: count of queued coin presses.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high.
- Reset state:
  - All outputs are 0.
  - Tick counter, debounce state and debounce counters are 0.
  - Coin FSM is in C_IDLE.
  - coin_pending is 0.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick is high in the cycle the counter equals TICK_DIV-1, and the counter then wraps to 0.
  - The first tick after reset release falls in cycle TICK_DIV-1.
  - The counter holds its value while pause=1, and no ticks occur.
- Debounce, applied per bit to bits 0..8:
  - Evaluated only on a tick.
  - If raw == deb: cnt <= 0.
  - Else if cnt == DEB_TICKS-1: deb <= raw and cnt <= 0.
  - Else: cnt++.
  - Result: a sustained change appears in deb on the DEB_TICKS-th tick after it is first sampled. Glitches shorter than that are rejected.
- Direction outputs (registered, one cycle after deb):
  - up = deb_up & ~deb_down; down = deb_down & ~deb_up.
  - left and right follow the same rule.
  - Both of a pair high gives 0 on both outputs.
- Button outputs: fire, bomb, start1, start2 are deb registered by one cycle.
- Pause effect on outputs:
  - While pause=1, the direction, fire, bomb, start1 and start2 outputs are forced to 0.
  - When pause falls they resume from the held deb state in the next cycle.
- Coin queue:
  - Each rising edge of deb_coin increments coin_pending, saturating at COIN_QUEUE. Edges arriving at saturation are dropped.
  - A dequeue in the same cycle as an edge leaves the count unchanged.
- Coin FSM, states C_IDLE, C_ON, C_GAP:
  - C_IDLE -> C_ON: on a tick with coin_pending > 0. Load cnt = COIN_ON_TICKS and decrement coin_pending.
  - C_ON: decrement on each tick. When cnt == 1 at a tick, go to C_GAP and load COIN_OFF_TICKS.
  - C_GAP: same countdown rule, then go to C_IDLE.
  - coin = (state == C_ON), registered.
  - The pulse lasts exactly COIN_ON_TICKS*TICK_DIV cycles; the gap lasts exactly COIN_OFF_TICKS*TICK_DIV cycles.
  - While pause=1 the FSM and the coin output hold their values, because no ticks occur.
- Reset mid-pulse: coin drops in the next cycle and the queue is cleared.

Decomposition:
- Package arcade_input_pkg holds:
  - JOY_RIGHT..JOY_COIN bit-index localparams.
  - The coin_state_t enum (C_IDLE, C_ON, C_GAP).
- One sub-module, input_debounce: a per-bit debouncer parameterised by width and DEB_TICKS, taking tick as an input. It is instantiated once for the 9 bits.
- The tick generator and coin FSM stay in the top module.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, DEB_TICKS=2, COIN_ON=3, COIN_OFF=2, COIN_QUEUE=3.
- Fire debounce: raise joy_in[4] at cycle 10 and hold -> fire=1 from one cycle after the 2nd tick sampling it high. A 1-tick glitch on fire -> fire stays 0.
- SOCD: joy_in[3:2]=2'b11 held -> up=down=0. Release down -> up=1 after the debounce latency.
- Single coin: one press held for 3 ticks -> coin high for exactly 12 cycles, then low for at least 8 cycles. coin_busy high for 20 cycles; coin_pending goes 1 -> 0 at pulse start.
- Queue saturation: 5 separate debounced coin presses during the first pulse -> coin_pending peaks at 3 (presses beyond the cap dropped). Exactly 4 pulses total, each 12 cycles high, separated by gaps of at least 8 cycles.
- Pause: assert pause for 40 cycles mid-pulse -> coin stays high and the pulse resumes with its remaining length. up/fire are forced 0 during pause and return 1 the cycle after pause falls. The tick counter value is unchanged across the pause.
- Reset mid-pulse with coin_pending=2 -> next cycle coin=0, coin_busy=0, coin_pending=0, and all outputs are 0.
